// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer
//   Reads a width x height frame in raster order from a synchronous pixel
//   memory (1-cycle read latency) and emits it as an o_de-qualified pixel
//   stream with frame/line markers, start-up blanking and inter-line blanking.
//
//   Optional build macro: FRAME_STREAMER_CONTINUOUS_EN
//     adds i_continuous; when high at the end of a frame the streamer restarts
//     the same frame (address 0, latched config) instead of returning to idle.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   i_start              start pulse, honoured only when idle with nonzero size
//   i_width, i_height    frame geometry, latched at start
//   i_start_up_delay     blank cycles before the first line
//   i_hsync_delay        blank cycles between lines
//   o_mem_rd, o_mem_addr memory read strobe and linear address
//   i_mem_rdata          memory data, valid one cycle after o_mem_rd
//   o_pixel, o_de        registered pixel and its qualifier
//   o_vsync, o_hsync     first pixel of frame / of line markers
//   o_row, o_col         coordinates of o_pixel
//   o_busy               high from accepted start until o_frame_done
//   o_frame_done         one-cycle pulse after the last o_de
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a start with nonzero width and height
// STARTUP | start-up blanking (at least one cycle)
// LINE    | one memory read per cycle along the current line
// HBLANK  | inter-line blanking, skipped when the delay is zero
// DRAIN   | waiting for the last read to leave the output pipeline
module frame_pixel_streamer #(
    parameter int W_SIZE       = 12,
    parameter int W_DELAY      = 12,
    parameter int W_FRAME_SIZE = 25,
    parameter int W_PIX        = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    i_start,
    input  logic [W_SIZE-1:0]       i_width,
    input  logic [W_SIZE-1:0]       i_height,
    input  logic [W_DELAY-1:0]      i_start_up_delay,
    input  logic [W_DELAY-1:0]      i_hsync_delay,
`ifdef FRAME_STREAMER_CONTINUOUS_EN
    input  logic                    i_continuous,
`endif
    output logic                    o_mem_rd,
    output logic [W_FRAME_SIZE-1:0] o_mem_addr,
    input  logic [W_PIX-1:0]        i_mem_rdata,
    output logic [W_PIX-1:0]        o_pixel,
    output logic                    o_de,
    output logic                    o_vsync,
    output logic                    o_hsync,
    output logic [W_SIZE-1:0]       o_row,
    output logic [W_SIZE-1:0]       o_col,
    output logic                    o_busy,
    output logic                    o_frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_STARTUP, S_LINE, S_HBLANK, S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [W_SIZE-1:0]       width_q, height_q, row_q, col_q;
    logic [W_DELAY-1:0]      sud_q, hsd_q, dly_q;
    logic [W_FRAME_SIZE-1:0] addr_q;

    logic                    rd_d1, hs_d1, vs_d1;
    logic [W_SIZE-1:0]       row_d1, col_d1;

    logic start_ok, last_col, last_row, dly_tc, restart;

    assign start_ok = (state_q == S_IDLE) && i_start &&
                      (i_width != '0) && (i_height != '0);
    assign last_col = (col_q == width_q - W_SIZE'(1));
    assign last_row = (row_q == height_q - W_SIZE'(1));
    // Down-counter terminal count; a zero delay still terminates after one cycle.
    assign dly_tc   = (dly_q <= W_DELAY'(1));

`ifdef FRAME_STREAMER_CONTINUOUS_EN
    assign restart = i_continuous;
`else
    assign restart = 1'b0;
`endif

    assign o_mem_addr = addr_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_ok) state_d = S_STARTUP;
            S_STARTUP: if (dly_tc) state_d = S_LINE;
            S_LINE: begin
                if (last_col) begin
                    if (last_row)            state_d = S_DRAIN;
                    else if (hsd_q != '0)    state_d = S_HBLANK;
                end
            end
            S_HBLANK:  if (dly_tc) state_d = S_LINE;
            S_DRAIN:   if (!rd_d1) state_d = restart ? S_STARTUP : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_mem_rd = (state_q == S_LINE);
        o_busy   = (state_q != S_IDLE);
    end

    // Config latch, blanking timer and raster counters.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            width_q  <= '0;
            height_q <= '0;
            sud_q    <= '0;
            hsd_q    <= '0;
            dly_q    <= '0;
            addr_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else if (start_ok) begin
            width_q  <= i_width;
            height_q <= i_height;
            sud_q    <= i_start_up_delay;
            hsd_q    <= i_hsync_delay;
            dly_q    <= i_start_up_delay;
            addr_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            case (state_q)
                S_STARTUP, S_HBLANK: begin
                    if (!dly_tc) dly_q <= dly_q - W_DELAY'(1);
                end
                S_LINE: begin
                    if (last_col) begin
                        col_q <= '0;
                        // Address stays on the final pixel once the frame is read.
                        if (!last_row) begin
                            row_q  <= row_q + W_SIZE'(1);
                            dly_q  <= hsd_q;
                            addr_q <= addr_q + W_FRAME_SIZE'(1);
                        end
                    end else begin
                        col_q  <= col_q + W_SIZE'(1);
                        addr_q <= addr_q + W_FRAME_SIZE'(1);
                    end
                end
                S_DRAIN: begin
                    if (state_d == S_STARTUP) begin
                        addr_q <= '0;
                        row_q  <= '0;
                        col_q  <= '0;
                        dly_q  <= sud_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Two-stage sideband shift: stage 1 lines up with i_mem_rdata,
    // stage 2 is the registered output.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_d1        <= 1'b0;
            hs_d1        <= 1'b0;
            vs_d1        <= 1'b0;
            row_d1       <= '0;
            col_d1       <= '0;
            o_pixel      <= '0;
            o_de         <= 1'b0;
            o_hsync      <= 1'b0;
            o_vsync      <= 1'b0;
            o_row        <= '0;
            o_col        <= '0;
            o_frame_done <= 1'b0;
        end else begin
            rd_d1   <= (state_q == S_LINE);
            hs_d1   <= (col_q == '0);
            vs_d1   <= (col_q == '0) && (row_q == '0);
            row_d1  <= row_q;
            col_d1  <= col_q;
            o_de    <= rd_d1;
            o_hsync <= rd_d1 && hs_d1;
            o_vsync <= rd_d1 && vs_d1;
            if (rd_d1) begin
                o_pixel <= i_mem_rdata;
                o_row   <= row_d1;
                o_col   <= col_d1;
            end
            o_frame_done <= (state_q == S_DRAIN) && !rd_d1;
        end
    end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
module tb_frame_pixel_streamer;
    localparam int W_SIZE       = 12;
    localparam int W_DELAY      = 12;
    localparam int W_FRAME_SIZE = 25;
    localparam int W_PIX        = 32;

    logic                    HCLK = 1'b0;
    logic                    HRESETn = 1'b0;
    logic                    i_start = 1'b0;
    logic [W_SIZE-1:0]       i_width = '0;
    logic [W_SIZE-1:0]       i_height = '0;
    logic [W_DELAY-1:0]      i_start_up_delay = '0;
    logic [W_DELAY-1:0]      i_hsync_delay = '0;
`ifdef FRAME_STREAMER_CONTINUOUS_EN
    logic                    i_continuous = 1'b0;
`endif
    logic                    o_mem_rd;
    logic [W_FRAME_SIZE-1:0] o_mem_addr;
    logic [W_PIX-1:0]        i_mem_rdata = '0;
    logic [W_PIX-1:0]        o_pixel;
    logic                    o_de, o_vsync, o_hsync, o_busy, o_frame_done;
    logic [W_SIZE-1:0]       o_row, o_col;

    frame_pixel_streamer #(
        .W_SIZE(W_SIZE), .W_DELAY(W_DELAY),
        .W_FRAME_SIZE(W_FRAME_SIZE), .W_PIX(W_PIX)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .i_start(i_start),
        .i_width(i_width), .i_height(i_height),
        .i_start_up_delay(i_start_up_delay), .i_hsync_delay(i_hsync_delay),
`ifdef FRAME_STREAMER_CONTINUOUS_EN
        .i_continuous(i_continuous),
`endif
        .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_rdata(i_mem_rdata),
        .o_pixel(o_pixel), .o_de(o_de), .o_vsync(o_vsync), .o_hsync(o_hsync),
        .o_row(o_row), .o_col(o_col), .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    logic [31:0] m_base = 32'h0;
    // Synchronous memory: word = base + address.
    always @(posedge HCLK) if (o_mem_rd) i_mem_rdata <= m_base + 32'(o_mem_addr);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Frame model: start cycle, geometry, delays, frame count.
    bit m_act = 0;
    int m_s = 0, m_w = 1, m_h = 1, m_su = 0, m_hs = 0, m_nf = 1;

    task automatic model(input int n, output bit e_rd, output int e_addr, output bit e_de,
                         output int e_r, output int e_c, output bit e_busy, output bit e_fd);
        int ms, p, per, k, sk, off;
        e_rd = 0; e_addr = 0; e_de = 0; e_r = 0; e_c = 0; e_busy = 0; e_fd = 0;
        if (m_act && n > m_s) begin
            ms  = (m_su == 0) ? 1 : m_su;
            p   = m_w + m_hs;
            // cycles from one frame's first STARTUP cycle to the next one's
            per = ms + (m_h - 1) * p + m_w + 2;
            e_busy = (n < m_s + m_nf * per + 1);
            e_fd   = (n > m_s + 1) && ((n - m_s - 1) % per == 0) && ((n - m_s - 1) / per <= m_nf);
            k = (n - m_s - 1) / per;
            if (k < m_nf) begin
                sk  = m_s + k * per;
                off = n - sk - 1 - ms;
                if (off >= 0 && off / p < m_h && off % p < m_w) begin
                    e_rd = 1; e_addr = (off / p) * m_w + off % p;
                end
                off = off - 2;
                if (off >= 0 && off / p < m_h && off % p < m_w) begin
                    e_de = 1; e_r = off / p; e_c = off % p;
                end
            end
        end
    endtask

    bit chk_en = 0;
    logic [31:0] exp_pix = 32'h0;
    int de_cnt, hs_cnt, vs_cnt, fd_cnt, rd_cnt;
    int first_de_cyc, last_de_cyc, fd_cyc;
    logic [31:0] first_pix, last_pix, first_rd_addr, last_rd_addr, last_row, last_col;

    task automatic clear_stats();
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fd_cnt = 0; rd_cnt = 0;
        first_de_cyc = 0; last_de_cyc = 0; fd_cyc = 0;
        first_pix = 0; last_pix = 0; first_rd_addr = 32'hffff_ffff; last_rd_addr = 0;
        last_row = 0; last_col = 0;
    endtask

    always @(negedge HCLK) begin
        bit e_rd, e_de, e_busy, e_fd;
        int e_addr, e_r, e_c;
        if (chk_en) begin
            model(cyc, e_rd, e_addr, e_de, e_r, e_c, e_busy, e_fd);
            check("mem_rd", 32'(o_mem_rd), 32'(e_rd));
            if (e_rd) check("mem_addr", 32'(o_mem_addr), e_addr);
            check("de", 32'(o_de), 32'(e_de));
            check("busy", 32'(o_busy), 32'(e_busy));
            check("frame_done", 32'(o_frame_done), 32'(e_fd));
            if (e_de) begin
                exp_pix = m_base + 32'(e_r * m_w + e_c);
                check("row", 32'(o_row), e_r);
                check("col", 32'(o_col), e_c);
            end
            check("pixel", o_pixel, exp_pix);
            check("hsync", 32'(o_hsync), 32'(e_de && e_c == 0));
            check("vsync", 32'(o_vsync), 32'(e_de && e_c == 0 && e_r == 0));
            if (o_de) begin
                de_cnt++;
                if (de_cnt == 1) begin first_de_cyc = cyc; first_pix = o_pixel; end
                last_de_cyc = cyc; last_pix = o_pixel;
                last_row = 32'(o_row); last_col = 32'(o_col);
            end
            if (o_hsync) hs_cnt++;
            if (o_vsync) vs_cnt++;
            if (o_frame_done) begin fd_cnt++; fd_cyc = cyc; end
            if (o_mem_rd) begin
                rd_cnt++;
                if (rd_cnt == 1) first_rd_addr = 32'(o_mem_addr);
                last_rd_addr = 32'(o_mem_addr);
            end
        end
    end

    int start_cyc;

    // Starts a frame, optionally pulses a second start at restart_at, scrambles
    // the config inputs mid-frame and runs until the frame(s) have finished.
    task automatic run_frame(input int w, input int h, input int su, input int hs,
                             input logic [31:0] base, input int nf, input int restart_at);
        int ms, per;
        @(negedge HCLK);
        clear_stats();
        m_w = w; m_h = h; m_su = su; m_hs = hs; m_nf = nf; m_base = base;
        m_s = cyc; start_cyc = cyc; m_act = 1;
        i_width = W_SIZE'(w); i_height = W_SIZE'(h);
        i_start_up_delay = W_DELAY'(su); i_hsync_delay = W_DELAY'(hs);
`ifdef FRAME_STREAMER_CONTINUOUS_EN
        i_continuous = (nf > 1);
`endif
        i_start = 1'b1;
        ms  = (su == 0) ? 1 : su;
        per = ms + (h - 1) * (w + hs) + w + 2;
        for (int i = 1; i <= nf * per + 4; i++) begin
            @(negedge HCLK);
            i_start = (i == restart_at);
            if (i == 1) begin
                i_width = 12'd7; i_height = 12'd9;
                i_start_up_delay = 12'd5; i_hsync_delay = 12'd4;
            end
`ifdef FRAME_STREAMER_CONTINUOUS_EN
            if (i == per + 2) i_continuous = 1'b0;
`endif
        end
        i_start = 1'b0;
    endtask

    initial begin
        clear_stats();
        repeat (3) @(negedge HCLK);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_de", 32'(o_de), 0);
        check("rst_rd", 32'(o_mem_rd), 0);
        check("rst_addr", 32'(o_mem_addr), 0);
        check("rst_pixel", o_pixel, 0);
        check("rst_done", 32'(o_frame_done), 0);
        HRESETn = 1'b1;
        chk_en = 1;
        repeat (2) @(negedge HCLK);

        // 4x2, delays 3/2, word = address
        run_frame(4, 2, 3, 2, 32'h0, 1, 0);
        check("t1_de_cnt", de_cnt, 8);
        check("t1_first_de_lat", first_de_cyc - start_cyc, 6);
        check("t1_done_after_last", fd_cyc - last_de_cyc, 1);
        check("t1_last_pix", last_pix, 7);
        check("t1_done_cnt", fd_cnt, 1);

        // 4x3, delays 0/0: gapless stream
        run_frame(4, 3, 0, 0, 32'h100, 1, 0);
        check("t2_de_cnt", de_cnt, 12);
        check("t2_gapless", last_de_cyc - first_de_cyc, 11);
        check("t2_hsync_cnt", hs_cnt, 3);
        check("t2_vsync_cnt", vs_cnt, 1);
        check("t2_first_pix", first_pix, 32'h100);

        // zero width / zero height starts are ignored
        @(negedge HCLK);
        clear_stats();
        m_act = 0;
        i_width = 12'd0; i_height = 12'd4; i_start = 1'b1;
        @(negedge HCLK);
        i_width = 12'd4; i_height = 12'd0;
        @(negedge HCLK);
        i_start = 1'b0;
        repeat (20) @(negedge HCLK);
        check("t3_no_reads", rd_cnt, 0);
        check("t3_no_de", de_cnt, 0);

        // second start mid-frame, config scrambled mid-frame
        run_frame(3, 3, 1, 1, 32'h2000, 1, 5);
        check("t4_de_cnt", de_cnt, 9);
        check("t4_done_cnt", fd_cnt, 1);
        check("t4_last_pix", last_pix, 32'h2008);

        // async reset after pixel 5 of a 4x4 frame (delays 2/1: pixel 5 at start+11)
        @(negedge HCLK);
        clear_stats();
        m_w = 4; m_h = 4; m_su = 2; m_hs = 1; m_nf = 1; m_base = 32'h1000;
        m_s = cyc; m_act = 1;
        i_width = 12'd4; i_height = 12'd4; i_start_up_delay = 12'd2; i_hsync_delay = 12'd1;
        i_start = 1'b1;
        @(negedge HCLK);
        i_start = 1'b0;
        repeat (10) @(negedge HCLK);
        #1;
        check("t5_de_before_rst", de_cnt, 6);
        chk_en = 0;
        #2;
        HRESETn = 1'b0;
        #1;
        check("t5_rst_de", 32'(o_de), 0);
        check("t5_rst_pixel", o_pixel, 0);
        check("t5_rst_busy", 32'(o_busy), 0);
        check("t5_rst_rd", 32'(o_mem_rd), 0);
        check("t5_rst_addr", 32'(o_mem_addr), 0);
        check("t5_rst_rowcol", 32'({o_row, o_col}), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            check("t5_no_done", 32'(o_frame_done), 0);
        end
        HRESETn = 1'b1;
        m_act = 0;
        exp_pix = 32'h0;
        chk_en = 1;
        repeat (4) @(negedge HCLK);
        run_frame(2, 2, 0, 0, 32'h55, 1, 0);
        check("t5_restart_addr0", first_rd_addr, 0);
        check("t5_restart_pix", first_pix, 32'h55);
        check("t5_restart_de", de_cnt, 4);

        // 128x128, delays 200/160
        run_frame(128, 128, 200, 160, 32'h0, 1, 0);
        check("t6_de_cnt", de_cnt, 16384);
        check("t6_last_row", last_row, 127);
        check("t6_last_col", last_col, 127);
        check("t6_last_addr", last_rd_addr, 16383);
        check("t6_last_pix", last_pix, 16383);

`ifdef FRAME_STREAMER_CONTINUOUS_EN
        // continuous mode: two 2x2 frames, cleared during the second
        run_frame(2, 2, 1, 1, 32'h300, 2, 0);
        check("t7_done_cnt", fd_cnt, 2);
        check("t7_vsync_cnt", vs_cnt, 2);
        check("t7_de_cnt", de_cnt, 8);
        check("t7_busy_after", 32'(o_busy), 0);
`endif

        repeat (3) @(negedge HCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_pixel_streamer.md
Name: frame_pixel_streamer

Overview:
- Source-side image streamer: fetches a WIDTH x HEIGHT frame, raster order, from a synchronous pixel memory (1-cycle read latency).
- Emits each pixel as a `valid` (o_de)-qualified stream with frame/line markers and programmable start-up and inter-line (hsync) blanking.
- Feeds the CNN accelerator input path; it is the reader counterpart of the bmp writer sink that consumes `out_pixel`/`out_valid`.
- Configured from the AHB register block (frame size, width/height, delay params); started by the layer-start pulse.

Parameters:
- W_SIZE, 12, width of width/height fields and row/col counters
- W_DELAY, 12, width of start-up and hsync delay fields
- W_FRAME_SIZE, 25, width of the linear memory address (2*W_SIZE+1)
- W_PIX, 32, pixel word width (4 channels x 8 bit)

Ports:
- HCLK  input  1  clock; all logic on rising edge
- HRESETn  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle start pulse; sampled only in IDLE
- i_width  input  W_SIZE  pixels per line; latched at start
- i_height  input  W_SIZE  lines per frame; latched at start
- i_start_up_delay  input  W_DELAY  idle cycles before first read
- i_hsync_delay  input  W_DELAY  idle cycles between lines
- o_mem_rd  output  1  memory read strobe
- o_mem_addr  output  W_FRAME_SIZE  linear pixel address, row*width+col
- i_mem_rdata  input  W_PIX  read data, valid 1 cycle after o_mem_rd
- o_pixel  output  W_PIX  registered pixel
- o_de  output  1  o_pixel valid
- o_vsync  output  1  one-cycle pulse with first o_de of frame
- o_hsync  output  1  one-cycle pulse with first o_de of each line
- o_row  output  W_SIZE  row of current o_pixel
- o_col  output  W_SIZE  column of current o_pixel
- o_busy  output  1  high from accepted start until o_frame_done
- o_frame_done  output  1  one-cycle pulse after last o_de

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Reset is asynchronous at any time, including mid-frame: frame aborts, no o_frame_done, counters cleared.
- FSM states: IDLE, STARTUP, LINE, HBLANK, DRAIN.
- IDLE:
  - On i_start with i_width!=0 and i_height!=0: latch config, o_busy=1, go to STARTUP.
  - Start with zero width or height is ignored.
- STARTUP:
  - Counts i_start_up_delay cycles, then goes to LINE.
  - Delay 0: exactly one cycle in STARTUP, no extra wait.
- LINE:
  - o_mem_rd=1 every cycle; o_mem_addr increments by 1 from 0. The address is a running counter (no multiplier).
  - col counts 0..width-1. At col==width-1:
    - last row: go to DRAIN;
    - otherwise: row++, col=0, go to HBLANK.
- HBLANK:
  - o_mem_rd=0; counts i_hsync_delay cycles, then LINE.
  - Delay 0: HBLANK skipped; the next line is read back-to-back.
- Pipeline:
  - Read issued at cycle t; i_mem_rdata sampled at t+1; o_pixel/o_de/o_row/o_col/o_hsync/o_vsync registered at t+2.
  - Fixed latency is 2 cycles from o_mem_rd to o_de.
  - row/col/marker sidebands are carried through a 2-stage shift aligned with the data.
- DRAIN:
  - Waits until the final o_de has been emitted.
  - o_frame_done pulses the cycle after the last o_de; o_busy drops in the same cycle; return to IDLE.
- o_pixel holds its last value when o_de=0.
- i_start while o_busy=1 is ignored. Config inputs changing mid-frame have no effect.
- Width-1 frames: o_hsync and o_vsync both pulse on the single first pixel; every line still respects hsync delay.
- Frame pixel count = width*height and must fit in W_FRAME_SIZE. The address never wraps within a legal frame.

Optional Feature:
- Macro: FRAME_STREAMER_CONTINUOUS_EN.
- When defined:
  - Adds input i_continuous (1 bit).
  - If i_continuous=1 at the end of DRAIN, o_frame_done still pulses.
  - The FSM then re-enters STARTUP with the latched config (address back to 0) instead of IDLE; o_busy stays high.
  - Deasserting i_continuous stops the stream after the current frame.
- When undefined: port absent; always returns to IDLE after one frame.

Test Plan:
- 4x2 frame, delays 3/2, memory word = address:
  - 8 o_de pulses, o_pixel 0..7 in order.
  - First o_de at start+1+3+2 cycles; 2 idle cycles between lines.
  - o_frame_done one cycle after pixel 7.
- Delays 0/0, 4x3 frame: 12 consecutive o_de cycles with no gaps; o_hsync at pixels 0,4,8; o_vsync at pixel 0 only.
- Edge and ignored starts:
  - i_start with width=0: o_busy stays 0, no memory reads.
  - Second i_start mid-frame: no restart; pixel count stays width*height.
- HRESETn low after pixel 5 of a 4x4 frame:
  - All outputs 0 immediately.
  - No o_frame_done.
  - A new start streams from address 0.
- 128x128 frame with delays 200/160: 16384 o_de; o_row/o_col correct at pixel 16383 (127,127); last o_mem_addr = 16383.
- FRAME_STREAMER_CONTINUOUS_EN with i_continuous=1 for 2 frames of 2x2:
  - Two o_frame_done pulses and two o_vsync pulses.
  - o_busy high throughout; drops after the frame in which i_continuous was cleared.
